// File: rtl/range_framer.sv
// range_framer: buffers a valid/ready sample stream with end-of-frame markers
// and replays it as a continuous per-cycle stream bracketed by go/finish pulses.
module range_framer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             go,
  output logic             finish,
  output logic             frame_active,
  output logic [15:0]      frames_done,
  output logic             underrun
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DONE_W = 16;

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  entry_t           head;

  state_t              state;
  state_t              state_nx;
  logic [WIDTH-1:0]    data_nx;
  logic                go_nx;
  logic                finish_nx;
  logic                active_nx;
  logic                underrun_nx;
  logic [DONE_W-1:0]   done_nx;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = ~full & rst_n;
  assign push     = in_valid & in_ready;
  assign head     = mem[rd_ptr];

  // Sample storage; contents need no reset since pointers/count gate reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_last, in_data};
    end
  end

  // FIFO pointers and occupancy; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // State and registered output stream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      data_out     <= '0;
      go           <= 1'b0;
      finish       <= 1'b0;
      frame_active <= 1'b0;
      frames_done  <= '0;
      underrun     <= 1'b0;
    end else begin
      state        <= state_nx;
      data_out     <= data_nx;
      go           <= go_nx;
      finish       <= finish_nx;
      frame_active <= active_nx;
      frames_done  <= done_nx;
      underrun     <= underrun_nx;
    end
  end

  // Next-state / pop decision; an empty FIFO mid-frame repeats the last sample.
  always_comb begin
    state_nx    = state;
    data_nx     = data_out;
    go_nx       = 1'b0;
    finish_nx   = 1'b0;
    active_nx   = 1'b0;
    underrun_nx = underrun;
    done_nx     = frames_done;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          data_nx   = head.data;
          go_nx     = 1'b1;
          active_nx = 1'b1;
          state_nx  = head.last ? FIN : RUN;
        end
      end
      RUN: begin
        active_nx = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          data_nx = head.data;
          if (head.last) begin
            finish_nx = 1'b1;
            done_nx   = frames_done + DONE_W'(1);
            state_nx  = IDLE;
          end
        end else begin
          underrun_nx = 1'b1;
        end
      end
      FIN: begin
        // Single-sample frame: hold the sample one more cycle for finish.
        active_nx = 1'b1;
        finish_nx = 1'b1;
        done_nx   = frames_done + DONE_W'(1);
        state_nx  = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_range_framer.sv
// Directed bench for range_framer with hand-derived expected output traces.
module tb_range_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] data_out;
  logic        go;
  logic        finish;
  logic        frame_active;
  logic [15:0] frames_done;
  logic        underrun;

  int vectors = 0;
  int miscompares = 0;

  range_framer #(.WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready),
    .data_out(data_out), .go(go), .finish(finish),
    .frame_active(frame_active), .frames_done(frames_done),
    .underrun(underrun)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
  endtask

  // Hard bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    logic [15:0] sd [30];
    logic        sl [30];
    int          idx;
    logic        acc;
    logic        saw_block;
    int          p;
    int          q;

    rst_n = 1'b0;
    drive(1'b0, 16'd0, 1'b0);
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_go", go, 0);
    chk("rst_finish", finish, 0);
    chk("rst_active", frame_active, 0);
    chk("rst_frames_done", frames_done, 0);
    chk("rst_underrun", underrun, 0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", in_ready, 1);

    // Basic frame 3, 9, 5.
    drive(1'b1, 16'd3, 1'b0); tick();
    chk("basic_no_early_go", go, 0);
    drive(1'b1, 16'd9, 1'b0); tick();
    chk("basic_d0", data_out, 3); chk("basic_go0", go, 1); chk("basic_fin0", finish, 0);
    chk("basic_act0", frame_active, 1);
    drive(1'b1, 16'd5, 1'b1); tick();
    chk("basic_d1", data_out, 9); chk("basic_go1", go, 0); chk("basic_fin1", finish, 0);
    drive(1'b0, 16'd0, 1'b0); tick();
    chk("basic_d2", data_out, 5); chk("basic_fin2", finish, 1); chk("basic_go2", go, 0);
    chk("basic_done", frames_done, 1);
    tick();
    chk("basic_idle_act", frame_active, 0); chk("basic_idle_fin", finish, 0);
    chk("basic_hold", data_out, 5); chk("basic_underrun", underrun, 0);

    // Single-sample frame 7.
    drive(1'b1, 16'd7, 1'b1); tick();
    drive(1'b0, 16'd0, 1'b0); tick();
    chk("single_d0", data_out, 7); chk("single_go0", go, 1); chk("single_fin0", finish, 0);
    tick();
    chk("single_d1", data_out, 7); chk("single_go1", go, 0); chk("single_fin1", finish, 1);
    chk("single_act1", frame_active, 1); chk("single_done", frames_done, 2);
    tick();
    chk("single_idle_act", frame_active, 0); chk("single_idle_fin", finish, 0);

    // Underrun: 4, three idle cycles, then 8 with last -> 4,4,4,4,8.
    drive(1'b1, 16'd4, 1'b0); tick();
    drive(1'b0, 16'd0, 1'b0); tick();
    chk("ur_d0", data_out, 4); chk("ur_go0", go, 1); chk("ur_flag0", underrun, 0);
    tick();
    chk("ur_d1", data_out, 4); chk("ur_go1", go, 0); chk("ur_flag1", underrun, 1);
    tick();
    chk("ur_d2", data_out, 4); chk("ur_act2", frame_active, 1);
    drive(1'b1, 16'd8, 1'b1); tick();
    chk("ur_d3", data_out, 4); chk("ur_fin3", finish, 0);
    drive(1'b0, 16'd0, 1'b0); tick();
    chk("ur_d4", data_out, 8); chk("ur_fin4", finish, 1); chk("ur_go4", go, 0);
    chk("ur_done", frames_done, 3);
    tick();
    chk("ur_sticky", underrun, 1); chk("ur_idle_act", frame_active, 0);

    // Backpressure: ten single-sample frames fill the FIFO, then a 20-sample frame.
    for (int i = 0; i < 30; i++) begin
      sd[i] = (i < 10) ? 16'(100 + i) : 16'(i - 10);
      sl[i] = (i < 10) || (i == 29);
    end
    idx = 0;
    saw_block = 1'b0;
    for (int e = 1; e <= 41; e++) begin
      if (idx < 30) drive(1'b1, sd[idx], sl[idx]);
      else          drive(1'b0, 16'd0, 1'b0);
      acc = in_valid & in_ready;
      if (!in_ready) saw_block = 1'b1;
      tick();
      if (acc) idx++;
      if (e >= 2) begin
        p = e - 2;
        if (p < 20) begin
          chk("bp_single_data", data_out, 32'(100 + p / 2));
          chk("bp_single_go", go, 32'(p % 2 == 0));
          chk("bp_single_fin", finish, 32'(p % 2 == 1));
        end else begin
          q = p - 20;
          chk("bp_frame_data", data_out, 32'(q));
          chk("bp_frame_go", go, 32'(q == 0));
          chk("bp_frame_fin", finish, 32'(q == 19));
        end
        chk("bp_active", frame_active, 1);
      end
    end
    drive(1'b0, 16'd0, 1'b0);
    chk("bp_all_accepted", idx, 30);
    chk("bp_ready_dropped", saw_block, 1);
    tick();
    chk("bp_idle_act", frame_active, 0);
    chk("bp_done", frames_done, 14);
    chk("bp_underrun_sticky", underrun, 1);

    // Back-to-back 2-sample frames across the frames_done wrap.
    force dut.frames_done = 16'hFFFE;
    #1;
    release dut.frames_done;
    chk("wrap_preload", frames_done, 32'hFFFE);
    for (int e = 1; e <= 7; e++) begin
      if (e <= 6) drive(1'b1, 16'(10 + e - 1), (e % 2 == 0));
      else        drive(1'b0, 16'd0, 1'b0);
      tick();
      if (e >= 2) begin
        chk("b2b_data", data_out, 32'(10 + e - 2));
        chk("b2b_go", go, 32'(e % 2 == 0));
        chk("b2b_fin", finish, 32'(e % 2 == 1));
        chk("b2b_active", frame_active, 1);
      end
      if (e == 3) chk("wrap_ffff", frames_done, 32'hFFFF);
      if (e == 5) chk("wrap_zero", frames_done, 0);
      if (e == 7) chk("wrap_one", frames_done, 1);
    end
    tick();
    chk("b2b_idle_act", frame_active, 0);

    // Reset in the middle of a 5-sample frame.
    drive(1'b1, 16'd20, 1'b0); tick();
    drive(1'b1, 16'd21, 1'b0); tick();
    chk("mid_go", go, 1); chk("mid_d0", data_out, 20);
    drive(1'b1, 16'd22, 1'b0); tick();
    chk("mid_d1", data_out, 21);
    rst_n = 1'b0;
    drive(1'b0, 16'd0, 1'b0);
    #1;
    chk("mid_rst_ready", in_ready, 0);
    tick();
    chk("mid_rst_data", data_out, 0); chk("mid_rst_go", go, 0);
    chk("mid_rst_fin", finish, 0); chk("mid_rst_act", frame_active, 0);
    chk("mid_rst_done", frames_done, 0); chk("mid_rst_ur", underrun, 0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_fin", finish, 0); chk("post_rst_go", go, 0);
    chk("post_rst_data", data_out, 0); chk("post_rst_act", frame_active, 0);
    drive(1'b1, 16'd30, 1'b0); tick();
    drive(1'b1, 16'd31, 1'b1); tick();
    chk("new_d0", data_out, 30); chk("new_go", go, 1);
    drive(1'b0, 16'd0, 1'b0); tick();
    chk("new_d1", data_out, 31); chk("new_fin", finish, 1);
    chk("new_done", frames_done, 1); chk("new_ur", underrun, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
